window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator.
- Sits directly upstream of the 3x3 mean/median filter functions.
- Accepts one raster-order pixel per accepted cycle and buffers the two previous image lines internally.
- Presents the nine pixels of each complete 3x3 window on in1..in9-style outputs, plus a valid strobe that drives the filter's enable.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 640, pixels per line; minimum 3
IMG_HEIGHT, 480, lines per frame; minimum 3

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
pix_in  input  DATA_WIDTH  incoming pixel, raster order
pix_valid  input  1  pix_in is accepted this cycle
frame_start  input  1  qualified by pix_valid; marks this pixel as (row 0, col 0)
w1..w9  output  DATA_WIDTH each  window pixels, row-major; w1 top-left (row r-2, col c-2), w5 centre, w9 bottom-right (row r, col c)
win_valid  output  1  one-cycle strobe: w1..w9 hold a new complete window
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async): w1..w9=0, win_valid=0, frame_done=0, col/row counters=0, window shift registers=0. Line-buffer contents need not be cleared, because the row gating below masks them.
- Accept: a pixel is accepted on a rising clk with pix_valid=1. With pix_valid=0 all state holds, including w1..w9. No backpressure; the block always accepts.
- Counters:
  - col counts 0..IMG_WIDTH-1 and wraps to 0 with row+1.
  - row counts 0..IMG_HEIGHT-1 and wraps to 0 after the last column of the last row.
- Line buffers:
  - Two line delays of IMG_WIDTH entries each.
  - At the accepted pixel (r,c), taps give pixels (r-1,c) and (r-2,c).
  - Register or RAM implementation is allowed; any RAM read latency must be hidden internally so the tap/pixel alignment is exact.
- Window:
  - Three 3-deep column shift registers (rows r-2, r-1, r) shift on each accepted pixel.
  - Columns from the previous line never mix into a new line's window, because validity is gated by col>=2.
- win_valid:
  - Registered, 1 cycle after accepting pixel (r,c) with r>=2 and c>=2.
  - In the same edge, w1..w9 load the window whose bottom-right is (r,c).
  - No border padding: border windows are dropped.
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes per frame.
  - w1..w9 hold their last values while win_valid=0.
- frame_done: registered pulse 1 cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1). It coincides with the final win_valid.
- frame_start:
  - When accepted, that pixel is treated as (0,0) regardless of the counters, and counting continues from it.
  - Mid-frame frame_start aborts the frame: no further windows from old rows, no frame_done for the aborted frame, and win_valid stays low until row 2 col 2 of the new frame.
  - frame_start at natural wrap is consistent and harmless.
- Simultaneous events: frame_start on the last pixel of a frame: the pixel is treated as (0,0) of a new frame; frame_done does not fire.
- Reset mid-frame: outputs zero immediately; the next accepted pixel is (0,0) even without frame_start.
- Downstream contract: w1..w9 map to filter in1..in9; win_valid drives filter enable. Filter output is therefore valid 1 cycle after win_valid.

Test Plan:
- Sizes/pattern: IMG_WIDTH=4, IMG_HEIGHT=4, DATA_WIDTH=8, pixel value = row*16+col, continuous pix_valid, frame_start on the first pixel.
- First window: after accepting (2,2), win_valid=1 for one cycle with w1..w9 = 00,01,02,10,11,12,20,21,22 (hex).
- Window count: over a full frame exactly 4 win_valid strobes, with bottom-right pixels 22,23,32,33. frame_done pulses together with the 33 window.
- Bubbles: random pix_valid gaps (~50% duty). The window sequence is identical to the continuous case, and outputs hold across gaps.
- Back-to-back frames:
  - No win_valid during rows 0–1 of frame 2, despite stale line-buffer data.
  - Frame 2's first window again has bottom-right 22.
- Mid-frame frame_start: assert at (2,3) of frame 1. No frame_done; the next win_valid occurs at new (2,2) with new-frame data only.
- Async reset mid-frame: assert rst at (3,1). w1..w9=0, win_valid=0 asynchronously; after release a fresh frame without frame_start yields its first window at (2,2).

Source files
------------

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator with two internal line buffers
module window_gen_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_pix_in,
    input  logic                  i_pix_valid,
    input  logic                  i_frame_start,
    output logic [DATA_WIDTH-1:0] o_w1,
    output logic [DATA_WIDTH-1:0] o_w2,
    output logic [DATA_WIDTH-1:0] o_w3,
    output logic [DATA_WIDTH-1:0] o_w4,
    output logic [DATA_WIDTH-1:0] o_w5,
    output logic [DATA_WIDTH-1:0] o_w6,
    output logic [DATA_WIDTH-1:0] o_w7,
    output logic [DATA_WIDTH-1:0] o_w8,
    output logic [DATA_WIDTH-1:0] o_w9,
    output logic                  o_win_valid,
    output logic                  o_frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] C_TWO = CW'(2);
    localparam logic [RW-1:0] R_TWO = RW'(2);
    logic [CW-1:0] r_col, w_col;
    logic [RW-1:0] r_row, w_row;
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_sr [3][2];
    logic [DATA_WIDTH-1:0] w_tap [3];
    logic [DATA_WIDTH-1:0] r_w [9];
    logic w_last_col, w_last_row, w_win;
    // frame_start overrides the counters so the accepted pixel is (0,0)
    always_comb begin
        w_col      = i_frame_start ? '0 : r_col;
        w_row      = i_frame_start ? '0 : r_row;
        w_tap[0]   = r_lb2[w_col];
        w_tap[1]   = r_lb1[w_col];
        w_tap[2]   = i_pix_in;
        w_last_col = w_col == C_LAST;
        w_last_row = w_row == R_LAST;
        w_win      = w_row >= R_TWO && w_col >= C_TWO;
    end
    always_ff @(posedge clk) begin
        if (i_pix_valid) begin
            r_lb2[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= i_pix_in;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_sr         <= '{default: '0};
            r_w          <= '{default: '0};
            o_win_valid  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_win_valid  <= i_pix_valid && w_win;
            o_frame_done <= i_pix_valid && w_last_col && w_last_row;
            if (i_pix_valid) begin
                r_col <= w_last_col ? '0 : w_col + 1'b1;
                r_row <= !w_last_col ? w_row : w_last_row ? '0 : w_row + 1'b1;
                for (int k = 0; k < 3; k++) begin
                    r_sr[k][0] <= w_tap[k];
                    r_sr[k][1] <= r_sr[k][0];
                    if (w_win) begin
                        r_w[3*k]   <= r_sr[k][1];
                        r_w[3*k+1] <= r_sr[k][0];
                        r_w[3*k+2] <= w_tap[k];
                    end
                end
            end
        end
    end
    assign o_w1 = r_w[0];
    assign o_w2 = r_w[1];
    assign o_w3 = r_w[2];
    assign o_w4 = r_w[3];
    assign o_w5 = r_w[4];
    assign o_w6 = r_w[5];
    assign o_w7 = r_w[6];
    assign o_w8 = r_w[7];
    assign o_w9 = r_w[8];
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: table vectors, directed corner sequences and random stress against a frame-image model
module tb_window_gen_3x3;
    localparam int W = 4;
    localparam int H = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] pix = '0;
    logic pv = 1'b0;
    logic fs = 1'b0;
    logic [7:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic wv, fd;
    int checks = 0;
    int errors = 0;
    window_gen_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .i_pix_in(pix), .i_pix_valid(pv), .i_frame_start(fs),
        .o_w1(w1), .o_w2(w2), .o_w3(w3), .o_w4(w4), .o_w5(w5),
        .o_w6(w6), .o_w7(w7), .o_w8(w8), .o_w9(w9),
        .o_win_valid(wv), .o_frame_done(fd)
    );
    always #5 clk = ~clk;
    // Reference: the current frame as a 2-D image, addressed by a linear pixel index
    logic [7:0] img [H][W];
    int p = 0;
    logic [71:0] m_win = '0;
    logic m_wv = 1'b0;
    logic m_fd = 1'b0;
    function automatic logic [71:0] win_now();
        return {w1, w2, w3, w4, w5, w6, w7, w8, w9};
    endfunction
    function automatic logic [71:0] br2win(input logic [7:0] b);
        logic [71:0] v;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[71-8*(3*i+j) -: 8] = b - 8'((2 - i) * 16 + (2 - j));
        return v;
    endfunction
    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask
    task automatic checkw(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask
    task automatic model_step(input logic v, input logic s, input logic [7:0] px);
        int r, c;
        m_wv = 1'b0;
        m_fd = 1'b0;
        if (v) begin
            if (s) p = 0;
            r = p / W;
            c = p % W;
            img[r][c] = px;
            if (r >= 2 && c >= 2) begin
                m_wv = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        m_win[71-8*(3*i+j) -: 8] = img[r-2+i][c-2+j];
            end
            m_fd = (p == W * H - 1);
            p = (p + 1) % (W * H);
        end
    endtask
    task automatic step(input logic v, input logic s, input logic [7:0] px);
        pv = v;
        fs = s;
        pix = px;
        @(posedge clk);
        model_step(v, s, px);
        #1;
        check1("win_valid", wv, m_wv);
        check1("frame_done", fd, m_fd);
        checkw("window", win_now(), m_win);
    endtask
    task automatic pattern_frame(input logic [7:0] base, input logic with_fs, input int first, input int last, input logic bubbles);
        for (int i = first; i <= last; i++) begin
            while (bubbles && $urandom_range(0, 1) == 1) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
            step(1'b1, with_fs && i == first, base + 8'((i / W) * 16 + i % W));
        end
    endtask
    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] px;
        logic       ewv;
        logic       efd;
        logic [7:0] ebr;
    } vec_t;
    vec_t tbl [16];
    initial begin
        logic [15:0] wv_mask;
        logic [15:0] fd_mask;
        logic [71:0] first_win;
        wv_mask = 16'hCC00;
        fd_mask = 16'h8000;
        first_win = 72'h000102101112202122;
        for (int i = 0; i < 16; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].s   = (i == 0);
            tbl[i].px  = 8'((i / 4) * 16 + i % 4);
            tbl[i].ewv = wv_mask[i];
            tbl[i].efd = fd_mask[i];
            tbl[i].ebr = tbl[i].px;
        end
        repeat (2) @(posedge clk);
        #1;
        check1("reset_win_valid", wv, 1'b0);
        check1("reset_frame_done", fd, 1'b0);
        checkw("reset_window", win_now(), '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pv = tbl[i].v;
            fs = tbl[i].s;
            pix = tbl[i].px;
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].s, tbl[i].px);
            #1;
            check1("tbl_win_valid", wv, tbl[i].ewv);
            check1("tbl_frame_done", fd, tbl[i].efd);
            if (tbl[i].ewv) checkw("tbl_window", win_now(), br2win(tbl[i].ebr));
            if (i == 10) checkw("first_window", win_now(), first_win);
        end
        step(1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 16; i++) step(1'b1, i == 0, 8'($urandom_range(0, 255)));
        pattern_frame(8'h00, 1'b1, 0, 15, 1'b1);
        pattern_frame(8'h40, 1'b1, 0, 15, 1'b1);
        // abort at (2,3): that pixel becomes (0,0) of a new frame
        pattern_frame(8'h00, 1'b1, 0, 10, 1'b0);
        pattern_frame(8'h80, 1'b1, 0, 15, 1'b0);
        // frame_start on the last pixel of a frame
        pattern_frame(8'h00, 1'b1, 0, 14, 1'b0);
        pattern_frame(8'hA0, 1'b1, 0, 15, 1'b0);
        // asynchronous reset at (3,1)
        pattern_frame(8'h00, 1'b1, 0, 12, 1'b0);
        pv = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_win = '0;
        m_wv = 1'b0;
        m_fd = 1'b0;
        p = 0;
        check1("async_rst_win_valid", wv, 1'b0);
        checkw("async_rst_window", win_now(), '0);
        @(posedge clk);
        #1;
        checkw("rst_hold_window", win_now(), '0);
        @(negedge clk);
        rst = 1'b0;
        pattern_frame(8'h50, 1'b0, 0, 15, 1'b0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
